// File: rtl/div_unit_pkg.sv
// Shared constants for the execute-stage divider: width, iteration count
// and the ALU op codes the divider honours.
package div_unit_pkg;

    localparam int N     = 32;
    localparam int CNT_W = $clog2(N);

    localparam logic [3:0] ADD  = 4'h0;
    localparam logic [3:0] SUB  = 4'h1;
    localparam logic [3:0] DIV  = 4'hA;
    localparam logic [3:0] DIVU = 4'hB;
    localparam logic [3:0] REM  = 4'hC;
    localparam logic [3:0] REMU = 4'hD;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

    // Two's complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] x, input logic is_signed);
        return (is_signed && x[N-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, try subtracting
// the divisor, keep the difference and set the quotient bit if it fits.
module div_step
    import div_unit_pkg::*;
(
    input  logic [N-1:0] rem,
    input  logic [N-1:0] quo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic [N-1:0] quo_next
);

    logic [N:0] rem_sh;
    logic [N:0] trial;

    // rem < divisor always holds, so the N+1-bit difference never wraps and
    // its MSB is a reliable borrow flag.
    always_comb begin
        rem_sh = {rem, quo[N-1]};
        trial  = rem_sh - {1'b0, divisor};
        if (!trial[N]) begin
            rem_next = trial[N-1:0];
            quo_next = {quo[N-2:0], 1'b1};
        end else begin
            rem_next = rem_sh[N-1:0];
            quo_next = {quo[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-cycle radix-2 divider for DIV/DIVU/REM/REMU in EX; stalls the
// front of the pipe while busy and pulses valid with the registered result.
//
// state | meaning
// IDLE  | no operation in flight
// BUSY  | one restoring step per cycle, counter 0..N-1
// DONE  | result registered, valid high for this single cycle
module div_unit
    import div_unit_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         kill,
    output logic         stall,
    output logic         valid,
    output logic [N-1:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     rem_q;
    logic [N-1:0]     quo_q;
    logic [N-1:0]     dvs_q;
    logic             neg_q;
    logic             neg_r;
    logic             sel_rem;

    logic             accept;
    logic             op_signed;
    logic             op_rem;
    logic             fast_zero;
    logic             fast_ovf;
    logic [N-1:0]     rem_nx;
    logic [N-1:0]     quo_nx;
    logic [N-1:0]     final_value;

    always_comb begin
        accept    = start && is_div_op(op) && !kill && (state != BUSY);
        op_signed = (op == DIV) || (op == REM);
        op_rem    = (op == REM) || (op == REMU);
        fast_zero = (inB == '0);
        fast_ovf  = op_signed && (inA == {1'b1, {(N-1){1'b0}}}) && (inB == '1);
        stall     = accept || (state == BUSY);
    end

    div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    // Sign correction is folded into the last step so result is already
    // correct in the DONE cycle that valid flags.
    always_comb begin
        if (sel_rem) final_value = neg_r ? (~rem_nx + 1'b1) : rem_nx;
        else         final_value = neg_q ? (~quo_nx + 1'b1) : quo_nx;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            result  <= '0;
            valid   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (kill) begin
                state <= IDLE;
            end else if (accept) begin
                sel_rem <= op_rem;
                cnt     <= '0;
                if (fast_zero) begin
                    result <= op_rem ? inA : '1;
                    valid  <= 1'b1;
                    state  <= DONE;
                end else if (fast_ovf) begin
                    result <= op_rem ? '0 : {1'b1, {(N-1){1'b0}}};
                    valid  <= 1'b1;
                    state  <= DONE;
                end else begin
                    rem_q <= '0;
                    quo_q <= magnitude(inA, op_signed);
                    dvs_q <= magnitude(inB, op_signed);
                    neg_q <= op_signed && (inA[N-1] ^ inB[N-1]);
                    neg_r <= op_signed && inA[N-1];
                    state <= BUSY;
                end
            end else begin
                case (state)
                    BUSY: begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(N-1)) begin
                            result <= final_value;
                            valid  <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-cycle radix-2 divider in the execute stage, beside the combinational ALU. It takes over the DIV, DIVU, REM and REMU operations so that no single-cycle divide path exists. It receives the same operands and 4-bit op code that ID/EX presents to the ALU. It stalls the front of the pipeline until its result is ready to be latched into EX/MEM.

## Interface
- N, 32, operand/result width; also the iteration count.
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  EX holds a divide-class instruction with valid operands.
- op  in  4  ALU op code; only `DIV`, `DIVU`, `REM`, `REMU` are honoured.
- inA  in  N  dividend, already forwarded.
- inB  in  N  divisor, already forwarded.
- kill  in  1  flush of the EX instruction; aborts any operation in flight.
- stall  out  1  combinational request to the hazard unit to freeze PC, IF/ID and ID/EX.
- valid  out  1  one-cycle pulse: result is correct this cycle.
- result  out  N  quotient or remainder as selected by the latched op.

## Operation
- States: IDLE, BUSY, DONE.
- A start is accepted when all of the following hold: start=1, op is one of the four divide codes, kill=0, state is IDLE or DONE.
- start with any other op is ignored: no state change, stall=0.
- On acceptance the block latches:
  - signedness: DIV and REM are signed.
  - select: REM and REMU select the remainder.
  - magnitudes |inA| and |inB|; two's complement, so 0x80000000 yields magnitude 0x80000000.
  - neg_q = signA XOR signB; neg_r = signA. Both are signed ops only.
- Fast paths, which go straight to DONE:
  - inB==0: quotient = all ones; remainder = inA.
  - signed, inA==0x80000000, inB==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- Otherwise: clear the partial remainder, load the quotient register with |inA|, clear the counter, go to BUSY.
- Each BUSY cycle performs one restoring step:
  - shift {rem, quo} left by 1.
  - trial = rem − |B| at N+1 bits.
  - if trial is non-negative, rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
- After step N (counter reaches N−1), go to DONE.
- DONE:
  - Apply the sign corrections: negate the quotient if neg_q; negate the remainder if neg_r.
  - Register the selected value into result; valid=1 for exactly that cycle.
  - Next state is IDLE, or a new acceptance if start is asserted.
- kill in BUSY or DONE: return to IDLE on the next edge; valid is not asserted afterwards; result holds its previous value.
- kill together with start: kill wins and nothing is accepted.
- result holds its last value until the next DONE.
- Reset values: state IDLE, counter 0, result 0, valid 0. stall is 0 because it follows from state IDLE.
- Reset mid-BUSY discards the operation; no valid is produced.

## Timing
- Cycle 0: edge E0 samples an accepted start. During cycle 0, stall=1 combinationally from start plus op decode, so ID/EX holds.
- Normal path:
  - BUSY for cycles 1..32; stall=1 throughout.
  - DONE in cycle 33: valid=1, stall=0, and EX/MEM latches result at the end of cycle 33.
  - Total occupancy is 34 cycles counting cycle 0.
- Fast paths: DONE in cycle 1; valid=1, stall=0.
- stall = (accepted start) OR (state==BUSY). It is never high in DONE.
- Back-to-back divides: a start in the DONE cycle is accepted, and BUSY resumes the next cycle.
- There is no combinational path from inA or inB to result.

## Structure
- `DIV`, `DIVU`, `REM`, `REMU` come from the shared constants include; no new codes are added.
- A state encoding localparam is local to the module.
- One sub-module, div_step: a combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - It is tested stand-alone.
- The top-level `ALUCPU` op decode keeps the divide codes, but the EX-stage mux selects div_unit.result for them.

## Test plan
- DIVU inA=100, inB=7, start one cycle -> stall=1 in cycles 0..32; valid in cycle 33 with result=14. Same operands with REMU -> result=2.
- DIV inA=0xFFFFFFF9 (−7), inB=2 -> result=0xFFFFFFFD (−3). REM with the same operands -> 0xFFFFFFFF (−1).
- DIVU 5/0 -> valid in cycle 1 with result=0xFFFFFFFF. REMU 5/0 -> result=5. stall is high in cycle 0 only.
- DIV 0x80000000/0xFFFFFFFF -> valid in cycle 1 with result=0x80000000. REM with the same operands -> 0.
- kill asserted in cycle 10 of a DIVU -> IDLE at cycle 11, no valid pulse, result unchanged. A new start in cycle 12 completes normally.
- reset low in cycle 5 of a DIV -> valid=0 and result=0 after the edge. A subsequent DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF at cycle 33. An ADD op with start=1 -> stall stays 0.
